imm_gen_pipe: RTL and testbench

Parametrised, handshaked immediate generator for the decode stage. It decodes every RV base immediate format (I, S, B, U, J) with correct sign extension to XLEN. Results pass through a registered output stage backed by a one-entry skid buffer, so execute-side stalls never drop an instruction. It sits between the IF/ID register and the ID/EX register, and carries a sideband tag alongside each result.

---
 rtl/imm_pkg.sv | 28 ++
 rtl/imm_gen_pipe_if.sv | 25 ++
 rtl/imm_decode.sv | 39 +++
 rtl/imm_gen_pipe.sv | 75 +++++++
 tb/tb_imm_gen_pipe.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: opcodes, immediate format codes and pipeline state encoding
package imm_pkg;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;
    // encoding is {out_full, skid_full}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_OUT   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: decode-side input handshake, execute-side output handshake and flush
interface imm_gen_pipe_if import imm_pkg::*; #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    imm_fmt_e         imm_fmt;
    logic [31:0]      inst_out;
    logic [TAG_W-1:0] tag_out;
    modport master (
        output flush, in_valid, inst, in_tag, out_ready,
        input  in_ready, out_valid, imm_out, imm_fmt, inst_out, tag_out
    );
    modport slave (
        input  flush, in_valid, inst, in_tag, out_ready,
        output in_ready, out_valid, imm_out, imm_fmt, inst_out, tag_out
    );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational RV immediate decoder, sign-extended to XLEN.
// Define IMM_CSR_EN to decode the CSR zimm (fmt Z) for SYSTEM opcodes with funct3[2]=1.
module imm_decode import imm_pkg::*; #(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);
    logic signed [31:0] imm32;
    always_comb begin
        fmt = FMT_NONE;
        case (inst[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                                  fmt = FMT_S;
            OPC_BRANCH:                                 fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
            OPC_JAL:                                    fmt = FMT_J;
`ifdef IMM_CSR_EN
            OPC_SYSTEM:                                 fmt = inst[14] ? FMT_Z : FMT_NONE;
`endif
            default:                                    fmt = FMT_NONE;
        endcase
    end
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_Z:   imm32 = {27'b0, inst[19:15]};
            default: imm32 = '0;
        endcase
    end
    // every format fits in 32 bits, so a signed widening cast covers XLEN=32 and 64
    assign imm = XLEN'(imm32);
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: handshaked immediate generator with a registered output and one-entry skid buffer.
// Optional CSR zimm decoding is enabled by defining IMM_CSR_EN.
module imm_gen_pipe import imm_pkg::*; #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);
    state_e           state, state_n;
    logic             accept, load_out, load_skid, from_skid;
    logic [XLEN-1:0]  dec_imm, skid_imm, out_imm;
    imm_fmt_e         dec_fmt, skid_fmt, out_fmt;
    logic [31:0]      skid_inst, out_inst;
    logic [TAG_W-1:0] skid_tag, out_tag;

    imm_decode #(.XLEN(XLEN)) u_dec (.inst(bus.inst), .imm(dec_imm), .fmt(dec_fmt));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            ST_EMPTY: state_n = accept ? ST_OUT : ST_EMPTY;
            ST_OUT:   state_n = bus.out_ready ? (accept ? ST_OUT : ST_EMPTY) : (accept ? ST_FULL : ST_OUT);
            ST_FULL:  state_n = bus.out_ready ? ST_OUT : ST_FULL;
            default:  state_n = ST_EMPTY;
        endcase
        state_n = bus.flush ? ST_EMPTY : state_n;
    end

    always_comb begin
        bus.in_ready  = state != ST_FULL;
        bus.out_valid = state != ST_EMPTY;
        accept        = bus.in_valid && bus.in_ready;
        from_skid     = state == ST_FULL;
        load_out      = (state == ST_EMPTY || bus.out_ready) && (accept || from_skid);
        load_skid     = state == ST_OUT && !bus.out_ready && accept;
    end

    // data written during a flush is harmless: the state forces out_valid low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm   <= '0;
            out_fmt   <= FMT_NONE;
            out_inst  <= '0;
            out_tag   <= '0;
            skid_imm  <= '0;
            skid_fmt  <= FMT_NONE;
            skid_inst <= '0;
            skid_tag  <= '0;
        end else begin
            if (load_out) begin
                out_imm  <= from_skid ? skid_imm  : dec_imm;
                out_fmt  <= from_skid ? skid_fmt  : dec_fmt;
                out_inst <= from_skid ? skid_inst : bus.inst;
                out_tag  <= from_skid ? skid_tag  : bus.in_tag;
            end
            if (load_skid) begin
                skid_imm  <= dec_imm;
                skid_fmt  <= dec_fmt;
                skid_inst <= bus.inst;
                skid_tag  <= bus.in_tag;
            end
        end
    end

    assign bus.imm_out  = out_imm;
    assign bus.imm_fmt  = out_fmt;
    assign bus.inst_out = out_inst;
    assign bus.tag_out  = out_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table-driven vectors plus scoreboard for imm_gen_pipe (XLEN=64)
module tb_imm_gen_pipe;
    import imm_pkg::*;
    localparam int XLEN = 64, TAG_W = 5, NV = 12;
    typedef struct { logic [31:0] inst; logic [63:0] imm; logic [2:0] fmt; } vec_t;
    typedef struct { logic [31:0] inst; logic [TAG_W-1:0] tag; logic [63:0] imm; logic [2:0] fmt; } exp_t;

    logic clk = 0, rst_n = 1;
    int   checks = 0, failures = 0, cyc = 0, t0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[NV];
    logic [63:0] h_imm, h_inst, h_tag;

    imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got inst %h tag %h with nothing pending", bus.inst_out, bus.tag_out);
        end else begin
            mon_e = sb.pop_front();
            chk("out_imm", bus.imm_out, mon_e.imm);
            chk("out_fmt", 64'(bus.imm_fmt), 64'(mon_e.fmt));
            chk("out_inst", bus.inst_out, mon_e.inst);
            chk("out_tag", 64'(bus.tag_out), 64'(mon_e.tag));
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] i, input logic [TAG_W-1:0] t, input logic [63:0] imm, input logic [2:0] fmt);
        int n = 0;
        bus.in_valid = 1;
        bus.inst     = i;
        bus.in_tag   = t;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready stuck at 0 for inst %h", i);
        end else sb.push_back('{i, t, imm, fmt});
        @(posedge clk);
        #1;
        bus.in_valid = 0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        chk(name, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({pfx, "_imm"}, bus.imm_out, 64'd0);
        chk({pfx, "_fmt"}, 64'(bus.imm_fmt), 64'd0);
        chk({pfx, "_inst"}, 64'(bus.inst_out), 64'd0);
        chk({pfx, "_tag"}, 64'(bus.tag_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.inst = '0; bus.in_tag = '0; bus.out_ready = 1;
        tbl[0]  = '{32'hFFC12083, 64'hFFFFFFFFFFFFFFFC, 3'd1};
        tbl[1]  = '{32'h80000063, 64'hFFFFFFFFFFFFF000, 3'd3};
        tbl[2]  = '{32'h00000463, 64'h0000000000000008, 3'd3};
        tbl[3]  = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4};
        tbl[4]  = '{32'h0010006F, 64'h0000000000000800, 3'd5};
        tbl[5]  = '{32'h00000033, 64'h0000000000000000, 3'd0};
`ifdef IMM_CSR_EN
        tbl[6]  = '{32'h340FD0F3, 64'h000000000000001F, 3'd6};
`else
        tbl[6]  = '{32'h340FD0F3, 64'h0000000000000000, 3'd0};
`endif
        tbl[7]  = '{32'hFE512C23, 64'hFFFFFFFFFFFFFFF8, 3'd2};
        tbl[8]  = '{32'h7FF00093, 64'h00000000000007FF, 3'd1};
        tbl[9]  = '{32'h12345097, 64'h0000000012345000, 3'd4};
        tbl[10] = '{32'h8000006F, 64'hFFFFFFFFFFF00000, 3'd5};
        tbl[11] = '{32'h00C0006F, 64'h000000000000000C, 3'd5};

        #1 rst_n = 0;
        #11 chk_zero("reset");
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

        send(tbl[0].inst, 5'd1, tbl[0].imm, tbl[0].fmt);
        chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
        t0 = cyc;
        for (int k = 1; k < NV; k++) send(tbl[k].inst, 5'(k + 1), tbl[k].imm, tbl[k].fmt);
        chk("throughput_cycles", 64'(cyc - t0), 64'(NV - 1));
        wait_drain("drain_stream");

        bus.out_ready = 0;
        send(tbl[3].inst, 5'd20, tbl[3].imm, tbl[3].fmt);
        send(tbl[7].inst, 5'd21, tbl[7].imm, tbl[7].fmt);
        @(negedge clk);
        chk("in_ready_full", 64'(bus.in_ready), 64'd0);
        chk("stall_head_inst", 64'(bus.inst_out), 64'(tbl[3].inst));
        h_imm = bus.imm_out; h_inst = 64'(bus.inst_out); h_tag = 64'(bus.tag_out);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_imm", bus.imm_out, h_imm);
            chk("stall_inst", 64'(bus.inst_out), h_inst);
            chk("stall_tag", 64'(bus.tag_out), h_tag);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1;
        send(tbl[10].inst, 5'd22, tbl[10].imm, tbl[10].fmt);
        send(tbl[1].inst, 5'd23, tbl[1].imm, tbl[1].fmt);
        wait_drain("drain_backpressure");

        bus.out_ready = 0;
        send(tbl[0].inst, 5'd10, tbl[0].imm, tbl[0].fmt);
        send(tbl[4].inst, 5'd11, tbl[4].imm, tbl[4].fmt);
        bus.in_valid = 1; bus.inst = tbl[9].inst; bus.in_tag = 5'd12; bus.flush = 1;
        @(posedge clk);
        #1;
        bus.flush = 0; bus.in_valid = 0;
        sb.delete();
        chk("flush_full_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_full_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1;
        send(tbl[8].inst, 5'd13, tbl[8].imm, tbl[8].fmt);
        wait_drain("drain_after_flush");
        chk("idle_after_flush", 64'(bus.out_valid), 64'd0);

        bus.out_ready = 0;
        send(tbl[2].inst, 5'd14, tbl[2].imm, tbl[2].fmt);
        bus.in_valid = 1; bus.inst = tbl[5].inst; bus.in_tag = 5'd15; bus.flush = 1;
        @(posedge clk);
        #1;
        bus.flush = 0; bus.in_valid = 0;
        sb.delete();
        bus.out_ready = 1;
        repeat (2) begin
            @(negedge clk);
            chk("flush_out_discard", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        bus.out_ready = 0;
        send(tbl[11].inst, 5'd7, tbl[11].imm, tbl[11].fmt);
        send(tbl[9].inst, 5'd8, tbl[9].imm, tbl[9].fmt);
        #2 rst_n = 0;
        #1 chk_zero("async_reset");
        chk("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        bus.out_ready = 1;
        chk("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
        send(tbl[6].inst, 5'd9, tbl[6].imm, tbl[6].fmt);
        wait_drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
